// File: rtl/ftdi_dev_pkg.sv
`default_nettype none
// ============================================================================
// Package    : ftdi_dev_pkg
// Purpose    : Shared types and constants for the FTDI sync 245-FIFO device
//              model (bus FSM state encoding and error-bit positions).
// Ports      : n/a (package)
// Revision   : 1.0 - initial release
// ============================================================================
package ftdi_dev_pkg;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      OE_ARMED = 2'd1,
      READ     = 2'd2,
      WRITE    = 2'd3
   } bus_state_t;

   localparam int ERR_RD_NO_OE   = 0;
   localparam int ERR_CONTENTION = 1;
   localparam int ERR_WR_FULL    = 2;
   localparam int ERR_BE         = 3;

endpackage
`default_nettype wire

// File: rtl/ftdi_sync_fifo.sv
`default_nettype none
// ============================================================================
// Module     : ftdi_sync_fifo
// Purpose    : Single-clock FIFO with a registered occupancy count. A push
//              and pop in the same cycle are both honoured even when full
//              (the pop frees the slot); an empty FIFO never pops.
// Ports      : tx_clk     - clock
//              rstn_async - asynchronous active-low reset
//              clr        - synchronous clear (held while the device is in reset)
//              push/push_data - write request and data
//              pop        - read request (consumes head)
//              head       - oldest word, 0 when empty
//              cnt        - registered occupancy, 0..2^AEXP
// Revision   : 1.0 - initial release
// ============================================================================
module ftdi_sync_fifo #(
   parameter int DW   = 8,
   parameter int AEXP = 4
) (
   input  logic            tx_clk,
   input  logic            rstn_async,
   input  logic            clr,
   input  logic            push,
   input  logic [DW-1:0]   push_data,
   input  logic            pop,
   output logic [DW-1:0]   head,
   output logic [AEXP:0]   cnt
);

   localparam int DEPTH = 1 << AEXP;

   logic [DW-1:0]   mem_q [DEPTH];
   logic [AEXP-1:0] wr_ptr_q, wr_ptr_d;
   logic [AEXP-1:0] rd_ptr_q, rd_ptr_d;
   logic [AEXP:0]   cnt_q, cnt_d;
   logic            empty, full, do_push, do_pop;

   assign empty   = (cnt_q == '0);
   assign full    = (cnt_q == DEPTH[AEXP:0]);
   assign do_pop  = pop & ~empty & ~clr;
   // A full FIFO can still take a word when the same edge frees a slot.
   assign do_push = push & (~full | do_pop) & ~clr;

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      cnt_d    = cnt_q;
      if (clr) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         cnt_d    = '0;
      end else begin
         if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
         if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
         if (do_push && !do_pop)      cnt_d = cnt_q + 1'b1;
         else if (do_pop && !do_push) cnt_d = cnt_q - 1'b1;
      end
   end

   always_ff @(posedge tx_clk or negedge rstn_async) begin
      if (!rstn_async) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         cnt_q    <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         cnt_q    <= cnt_d;
      end
   end

   // Storage needs no reset: the count gates visibility of every entry.
   always_ff @(posedge tx_clk) begin
      if (do_push) mem_q[wr_ptr_q] <= push_data;
   end

   assign head = empty ? '0 : mem_q[rd_ptr_q];
   assign cnt  = cnt_q;

endmodule
`default_nettype wire

// File: rtl/ftdi_245fifo_device.sv
`default_nettype none
// ============================================================================
// Module     : ftdi_245fifo_device
// Purpose    : Device-side model of an FTDI sync 245-FIFO chip. Serves
//              OE#/RD# reads from a host->device FIFO, captures WR# writes
//              into a device->host FIFO, and flags controller bus violations
//              in a sticky error register.
// Ports      : tx_clk/rstn_async      - clock, async active-low reset
//              usb_clk/rxf/txe        - chip outputs to the controller
//              usb_oe/rd/wr/be_i/data_i - controller strobes and bus
//              usb_data_o/usb_data_oe - device bus drive (tristate built above)
//              hin_*  / hout_*        - host-side valid/ready streams
//              stall_rx/stall_tx      - force rxf/txe inactive
//              err_clr/err            - sticky protocol violation flags
// Revision   : 1.0 - initial release
// ============================================================================
module ftdi_245fifo_device
   import ftdi_dev_pkg::*;
#(
   parameter int C_DEXP = 0,
   parameter int AEXP   = 4
) (
   input  logic                     tx_clk,
   input  logic                     rstn_async,
   output logic                     usb_clk,
   output logic                     usb_rxf,
   output logic                     usb_txe,
   input  logic                     usb_oe,
   input  logic                     usb_rd,
   input  logic                     usb_wr,
   input  logic [(8<<C_DEXP)-1:0]   usb_data_i,
   output logic [(8<<C_DEXP)-1:0]   usb_data_o,
   output logic                     usb_data_oe,
   input  logic [(1<<C_DEXP)-1:0]   usb_be_i,
   input  logic                     hin_valid,
   output logic                     hin_ready,
   input  logic [(8<<C_DEXP)-1:0]   hin_data,
   output logic                     hout_valid,
   input  logic                     hout_ready,
   output logic [(8<<C_DEXP)-1:0]   hout_data,
   input  logic                     stall_rx,
   input  logic                     stall_tx,
   input  logic                     err_clr,
   output logic [3:0]               err
);

   localparam int DW    = 8 << C_DEXP;
   localparam int DEPTH = 1 << AEXP;

   // Reset synchroniser: assertion is immediate, release takes two edges.
   logic [1:0] rst_sync_q, rst_sync_d;
   logic       rstn_i;

   assign rst_sync_d = {rst_sync_q[0], 1'b1};
   assign rstn_i     = rst_sync_q[1];

   always_ff @(posedge tx_clk or negedge rstn_async) begin
      if (!rstn_async) rst_sync_q <= '0;
      else             rst_sync_q <= rst_sync_d;
   end

   // FIFO status
   logic [AEXP:0] rx_cnt, tx_cnt;
   logic          rx_empty, rx_full, tx_empty, tx_full;

   assign rx_empty = (rx_cnt == '0);
   assign rx_full  = (rx_cnt == DEPTH[AEXP:0]);
   assign tx_empty = (tx_cnt == '0);
   assign tx_full  = (tx_cnt == DEPTH[AEXP:0]);

   assign usb_clk     = tx_clk;
   assign usb_rxf     = rx_empty | stall_rx | ~rstn_i;
   assign usb_txe     = tx_full  | stall_tx | ~rstn_i;
   assign usb_data_oe = rstn_i & ~usb_oe;
   assign hin_ready   = rstn_i & ~rx_full;
   assign hout_valid  = rstn_i & ~tx_empty;

   // Strobe decode
   logic rd_pop, tx_pop, rx_push, wr_accept, wr_drop;

   assign rd_pop  = ~usb_oe & ~usb_rd & ~usb_rxf;
   assign tx_pop  = hout_valid & hout_ready;
   assign rx_push = hin_valid & hin_ready;
   // A write landing on a full FIFO is still taken when the host drains a
   // word on the same edge, so no data is lost in that overlap.
   assign wr_accept = ~usb_wr & rstn_i & ~stall_tx & (~tx_full | tx_pop);
   assign wr_drop   = ~usb_wr & rstn_i & ~wr_accept;

   ftdi_sync_fifo #(.DW(DW), .AEXP(AEXP)) u_rx_fifo (
      .tx_clk     (tx_clk),
      .rstn_async (rstn_async),
      .clr        (~rstn_i),
      .push       (rx_push),
      .push_data  (hin_data),
      .pop        (rd_pop),
      .head       (usb_data_o),
      .cnt        (rx_cnt)
   );

   ftdi_sync_fifo #(.DW(DW), .AEXP(AEXP)) u_tx_fifo (
      .tx_clk     (tx_clk),
      .rstn_async (rstn_async),
      .clr        (~rstn_i),
      .push       (wr_accept),
      .push_data  (usb_data_i),
      .pop        (tx_pop),
      .head       (hout_data),
      .cnt        (tx_cnt)
   );

   // Bus FSM and protocol checker
   bus_state_t state_q, state_d;
   logic [3:0] err_q, err_d, err_set;

   always_comb begin
      state_d = state_q;
      err_set = '0;
      err_d   = err_q;

      case (state_q)
         IDLE: begin
            if (!usb_wr)                state_d = WRITE;
            else if (!usb_oe && usb_rd) state_d = OE_ARMED;
         end
         OE_ARMED: begin
            if (usb_oe)       state_d = IDLE;
            else if (!usb_rd) state_d = READ;
         end
         READ: begin
            if (usb_oe) state_d = IDLE;
         end
         WRITE: begin
            if (usb_wr) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase

      // RD# in IDLE means the controller skipped the OE#-only turnaround cycle.
      err_set[ERR_RD_NO_OE]   = ~usb_rd & (usb_oe | (state_q == IDLE));
      err_set[ERR_CONTENTION] = ~usb_wr & ~usb_oe;
      err_set[ERR_WR_FULL]    = wr_drop;
      err_set[ERR_BE]         = ~usb_wr & (usb_be_i != '1);

      if (err_clr) err_d = '0;
      else         err_d = err_q | err_set;

      if (!rstn_i) begin
         state_d = IDLE;
         err_d   = '0;
      end
   end

   always_ff @(posedge tx_clk or negedge rstn_async) begin
      if (!rstn_async) begin
         state_q <= IDLE;
         err_q   <= '0;
      end else begin
         state_q <= state_d;
         err_q   <= err_d;
      end
   end

   assign err = err_q;

endmodule
`default_nettype wire

// File: tb/tb_ftdi_245fifo_device.sv
`default_nettype none
// ============================================================================
// Module     : tb_ftdi_245fifo_device
// Purpose    : Self-checking bench for ftdi_245fifo_device (default params:
//              8-bit bus, 16-word FIFOs).
// Revision   : 1.0 - initial release
// ============================================================================
module tb_ftdi_245fifo_device;

   logic       tx_clk = 1'b0;
   logic       rstn_async;
   logic       usb_clk, usb_rxf, usb_txe;
   logic       usb_oe, usb_rd, usb_wr;
   logic [7:0] usb_data_i, usb_data_o;
   logic       usb_data_oe;
   logic [0:0] usb_be_i;
   logic       hin_valid, hin_ready;
   logic [7:0] hin_data;
   logic       hout_valid, hout_ready;
   logic [7:0] hout_data;
   logic       stall_rx, stall_tx, err_clr;
   logic [3:0] err;

   int total = 0;
   int bad   = 0;

   always #5 tx_clk = ~tx_clk;

   ftdi_245fifo_device #(.C_DEXP(0), .AEXP(4)) dut (
      .tx_clk      (tx_clk),
      .rstn_async  (rstn_async),
      .usb_clk     (usb_clk),
      .usb_rxf     (usb_rxf),
      .usb_txe     (usb_txe),
      .usb_oe      (usb_oe),
      .usb_rd      (usb_rd),
      .usb_wr      (usb_wr),
      .usb_data_i  (usb_data_i),
      .usb_data_o  (usb_data_o),
      .usb_data_oe (usb_data_oe),
      .usb_be_i    (usb_be_i),
      .hin_valid   (hin_valid),
      .hin_ready   (hin_ready),
      .hin_data    (hin_data),
      .hout_valid  (hout_valid),
      .hout_ready  (hout_ready),
      .hout_data   (hout_data),
      .stall_rx    (stall_rx),
      .stall_tx    (stall_tx),
      .err_clr     (err_clr),
      .err         (err)
   );

   typedef struct {
      string      name;
      logic       oe;
      logic       rd;
      logic       wr;
      logic       be;
      logic       clr;
      logic [3:0] err_exp;
   } vec_t;

   vec_t vecs[7];

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge tx_clk);
      #1;
   endtask

   task automatic bus_idle();
      usb_oe   = 1'b1;
      usb_rd   = 1'b1;
      usb_wr   = 1'b1;
      usb_be_i = 1'b1;
   endtask

   task automatic do_reset();
      rstn_async = 1'b0;
      hin_valid  = 1'b0;
      hout_ready = 1'b0;
      err_clr    = 1'b0;
      bus_idle();
      repeat (5) tick();
      rstn_async = 1'b1;
      repeat (3) tick();
   endtask

   task automatic push_hin(input logic [7:0] d);
      hin_valid = 1'b1;
      hin_data  = d;
      tick();
      hin_valid = 1'b0;
   endtask

   task automatic fill_tx16();
      usb_oe = 1'b1;
      for (int i = 0; i < 16; i++) begin
         usb_wr     = 1'b0;
         usb_data_i = 8'hA0 + 8'(i);
         tick();
      end
      usb_wr = 1'b1;
   endtask

   initial begin
      logic [7:0] rexp [3];
      rexp[0] = 8'h11; rexp[1] = 8'h22; rexp[2] = 8'h33;

      vecs[0] = '{"contention", 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 4'b0010};
      vecs[1] = '{"rd_no_oe",   1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 4'b0001};
      vecs[2] = '{"rd_in_idle", 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 4'b0001};
      vecs[3] = '{"be_zero",    1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 4'b1000};
      vecs[4] = '{"legal_wr",   1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 4'b0000};
      vecs[5] = '{"oe_arm",     1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 4'b0000};
      vecs[6] = '{"clr_wins",   1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 4'b0000};

      rstn_async = 1'b0;
      stall_rx   = 1'b0;
      stall_tx   = 1'b0;
      err_clr    = 1'b0;
      hin_valid  = 1'b0;
      hin_data   = 8'h00;
      hout_ready = 1'b0;
      usb_data_i = 8'h00;
      bus_idle();

      // 1: reset and synchronised release
      repeat (5) tick();
      check("rst_rxf", usb_rxf, 1'b1);
      check("rst_txe", usb_txe, 1'b1);
      check("rst_hin_ready", hin_ready, 1'b0);
      check("rst_err", err, 4'h0);
      check("rst_data_oe", usb_data_oe, 1'b0);
      rstn_async = 1'b1;
      tick();
      check("rel_edge1_txe", usb_txe, 1'b1);
      tick();
      tick();
      check("rel_edge3_txe", usb_txe, 1'b0);
      check("rel_edge3_rxf", usb_rxf, 1'b1);
      check("rel_hin_ready", hin_ready, 1'b1);
      check("usb_clk_fwd", usb_clk, tx_clk);

      // 2: read burst
      push_hin(8'h11); push_hin(8'h22); push_hin(8'h33);
      check("rd_rxf_avail", usb_rxf, 1'b0);
      usb_oe = 1'b0;
      #1;
      check("rd_data_oe_on", usb_data_oe, 1'b1);
      tick();
      usb_rd = 1'b0;
      for (int k = 0; k < 3; k++) begin
         #1;
         check($sformatf("rd_word%0d", k), usb_data_o, rexp[k]);
         tick();
      end
      check("rd_rxf_empty", usb_rxf, 1'b1);
      check("rd_head_zero", usb_data_o, 8'h00);
      bus_idle();
      #1;
      check("rd_data_oe_off", usb_data_oe, 1'b0);
      tick();
      check("rd_err_none", err, 4'h0);

      // 3: write fill, overflow, drain
      do_reset();
      fill_tx16();
      check("wr_txe_full", usb_txe, 1'b1);
      usb_wr     = 1'b0;
      usb_data_i = 8'hFF;
      tick();
      usb_wr = 1'b1;
      check("wr_overflow_err", err, 4'b0100);
      hout_ready = 1'b1;
      for (int i = 0; i < 16; i++) begin
         check($sformatf("hout_valid%0d", i), hout_valid, 1'b1);
         check($sformatf("hout_word%0d", i), hout_data, 8'hA0 + 8'(i));
         tick();
      end
      check("hout_empty", hout_valid, 1'b0);
      hout_ready = 1'b0;

      // 4: simultaneous pop and write on a full FIFO
      do_reset();
      fill_tx16();
      hout_ready = 1'b1;
      usb_wr     = 1'b0;
      usb_data_i = 8'h55;
      tick();
      usb_wr     = 1'b0;
      hout_ready = 1'b0;
      usb_wr     = 1'b1;
      check("sim_txe_still_full", usb_txe, 1'b1);
      check("sim_err_none", err, 4'h0);
      hout_ready = 1'b1;
      for (int i = 1; i < 17; i++) begin
         check($sformatf("sim_word%0d", i), hout_data, (i == 16) ? 8'h55 : 8'hA0 + 8'(i));
         tick();
      end
      check("sim_drained", hout_valid, 1'b0);
      hout_ready = 1'b0;

      // 5: protocol violations, table-driven
      do_reset();
      for (int v = 0; v < 7; v++) begin
         usb_oe   = vecs[v].oe;
         usb_rd   = vecs[v].rd;
         usb_wr   = vecs[v].wr;
         usb_be_i = vecs[v].be;
         err_clr  = vecs[v].clr;
         tick();
         check(vecs[v].name, err, vecs[v].err_exp);
         bus_idle();
         err_clr = 1'b1;
         tick();
         err_clr = 1'b0;
         check({vecs[v].name, "_clr"}, err, 4'h0);
      end

      // 6: reset in the middle of a read burst
      do_reset();
      push_hin(8'h01); push_hin(8'h02); push_hin(8'h03); push_hin(8'h04);
      usb_oe = 1'b0;
      tick();
      usb_rd = 1'b0;
      tick();
      check("mid_pre_data", usb_data_o, 8'h02);
      rstn_async = 1'b0;
      #1;
      check("mid_rxf_now", usb_rxf, 1'b1);
      check("mid_data_oe_now", usb_data_oe, 1'b0);
      check("mid_data_now", usb_data_o, 8'h00);
      tick();
      bus_idle();
      tick();
      rstn_async = 1'b1;
      repeat (3) tick();
      check("mid_rxf_after", usb_rxf, 1'b1);
      check("mid_data_after", usb_data_o, 8'h00);
      check("mid_err_after", err, 4'h0);

      // stall inputs mask the flags combinationally
      stall_tx = 1'b1;
      #1;
      check("stall_tx_txe", usb_txe, 1'b1);
      stall_tx = 1'b0;
      push_hin(8'h77);
      stall_rx = 1'b1;
      #1;
      check("stall_rx_rxf", usb_rxf, 1'b1);
      stall_rx = 1'b0;
      #1;
      check("stall_rx_off", usb_rxf, 1'b0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire
